// File: rtl/wb_master_ctrl_pkg.sv
// wb_master_ctrl_pkg: state encoding, beat stride and default timeout for the Wishbone initiator
package wb_master_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int WB_BEAT_INC        = 4;
   localparam int TIMEOUT_CYCLES_DEF = 255;

   // writes are always a single beat, reads carry LEN extra beats
   function automatic logic [3:0] beats_left(input logic we, input logic [3:0] len);
      return we ? 4'd0 : len;
   endfunction
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: per-beat ACK watchdog; expired is high on the LIMIT-th cycle of an enabled wait
module wb_timeout_cnt import wb_master_ctrl_pkg::*; #(
   parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = en && (cnt_q == CW'(LIMIT - 1));

   // count wait cycles, parking at the limit; clr holds the count at zero outside the wait
   always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + CW'(1) : cnt_q;

   // counter register
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
endmodule

// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl: Wishbone B4 classic initiator turning single writes / read bursts into CYC/STB cycles.
// Optional ACK watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_ctrl import wb_master_ctrl_pkg::*; #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                CLK_I,
   input  logic                RST_I,
   input  logic                CMD_VALID,
   output logic                CMD_READY,
   input  logic                CMD_WE,
   input  logic [ADDR_W-1:0]   CMD_ADDR,
   input  logic [DATA_W/8-1:0] CMD_SEL,
   input  logic [DATA_W-1:0]   CMD_DATA,
   input  logic [3:0]          CMD_LEN,
   output logic                RSP_VALID,
   input  logic                RSP_READY,
   output logic [DATA_W-1:0]   RSP_DATA,
   output logic                RSP_ERR,
   output logic                RSP_LAST,
   output logic                CYC_O,
   output logic                STB_O,
   output logic                WE_O,
   output logic [DATA_W/8-1:0] SEL_O,
   output logic [ADDR_W-1:0]   ADR_O,
   output logic [DATA_W-1:0]   DAT_O,
   input  logic                ACK_I,
   input  logic [DATA_W-1:0]   DAT_I
);
   localparam int SEL_W = DATA_W / 8;

   state_t              state_q, state_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_last_q, rsp_last_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   dat_q, dat_d, rsp_data_q, rsp_data_d;
   logic [3:0]          left_q, left_d;
   logic                tmo_exp;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef WB_MASTER_TIMEOUT_EN
   wb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
      .clk     (CLK_I),
      .rst     (RST_I),
      .clr     (state_q != ST_BUS),
      .en      (state_q == ST_BUS),
      .expired (tmo_exp)
   );
`else
   assign tmo_exp = 1'b0;
`endif

   // next-state and next-output computation for the command/bus/response sequencer
   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      left_d      = left_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      rsp_last_d  = rsp_last_q;
      case (state_q)
         ST_IDLE: begin
            cmd_ready_d = 1'b1;
            if (CMD_VALID && cmd_ready_q) begin
               state_d     = ST_BUS;
               cmd_ready_d = 1'b0;
               cyc_d       = 1'b1;
               stb_d       = 1'b1;
               we_d        = CMD_WE;
               sel_d       = CMD_SEL;
               adr_d       = CMD_ADDR;
               dat_d       = CMD_DATA;
               left_d      = beats_left(CMD_WE, CMD_LEN);
            end
         end
         ST_BUS: begin
            if (ACK_I) begin
               state_d     = ST_RESP;
               stb_d       = 1'b0;
               cyc_d       = |left_q;
               rsp_valid_d = 1'b1;
               rsp_data_d  = we_q ? '0 : DAT_I;
               rsp_last_d  = ~|left_q;
               rsp_err_d   = 1'b0;
            end else if (tmo_exp) begin
               state_d     = ST_RESP;
               stb_d       = 1'b0;
               cyc_d       = 1'b0;
               left_d      = 4'd0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_last_d  = 1'b1;
               rsp_err_d   = 1'b1;
            end
         end
         ST_RESP: begin
            if (RSP_READY) begin
               rsp_valid_d = 1'b0;
               rsp_data_d  = '0;
               rsp_last_d  = 1'b0;
               rsp_err_d   = 1'b0;
               if (|left_q) begin
                  state_d = ST_BUS;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  left_d  = left_q - 4'd1;
                  adr_d   = adr_q + ADDR_W'(WB_BEAT_INC);
               end else begin
                  state_d     = ST_IDLE;
                  cmd_ready_d = 1'b1;
                  we_d        = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state and registered outputs; async reset drops the bus cycle immediately
   always_ff @(posedge CLK_I or posedge RST_I)
      if (RST_I) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         left_q      <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         left_q      <= left_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_last_q  <= rsp_last_d;
      end

   assign CMD_READY = cmd_ready_q;
   assign CYC_O     = cyc_q;
   assign STB_O     = stb_q;
   assign WE_O      = we_q;
   assign SEL_O     = sel_q;
   assign ADR_O     = adr_q;
   assign DAT_O     = dat_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA  = rsp_data_q;
   assign RSP_ERR   = rsp_err_q;
   assign RSP_LAST  = rsp_last_q;
endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb_wb_master_ctrl: randomized self-checking bench for wb_master_ctrl (timeout scenario when WB_MASTER_TIMEOUT_EN is defined)
module tb_wb_master_ctrl;
`ifdef WB_MASTER_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_data = '0;
   logic [3:0]  cmd_sel = '0, cmd_len = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_last;
   logic [31:0] rsp_data;
   logic        cyc, stb, we, ack;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o, dat_i;

   int n_cmp = 0, n_bad = 0;

   wb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK_I(clk), .RST_I(rst),
      .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WE(cmd_we), .CMD_ADDR(cmd_addr),
      .CMD_SEL(cmd_sel), .CMD_DATA(cmd_data), .CMD_LEN(cmd_len),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err), .RSP_LAST(rsp_last),
      .CYC_O(cyc), .STB_O(stb), .WE_O(we), .SEL_O(sel), .ADR_O(adr), .DAT_O(dat_o),
      .ACK_I(ack), .DAT_I(dat_i)
   );

   always #5 clk = ~clk;

   // responder: ACK after `waits` strobe cycles, read data = address ^ key
   logic        ack_en = 1'b1;
   int          waits = 0, wcnt = 0;
   logic [31:0] key = '0;
   assign ack   = ack_en && cyc && stb && (wcnt >= waits);
   assign dat_i = adr ^ key;
   always @(posedge clk) wcnt <= (stb && !ack) ? wcnt + 1 : 0;

   // bus monitor: acked transfers, strobe pulse lengths, CYC falling edges
   logic [31:0] ack_adr[64], ack_dat[64];
   logic        ack_we[64];
   logic [3:0]  ack_sel[64];
   int          n_ack = 0, n_pulse = 0, stb_run = 0, cyc_falls = 0;
   int          stb_len[64];
   logic        cyc_prev = 1'b0;
   always @(posedge clk) begin
      if (cyc && stb && ack && n_ack < 64) begin
         ack_adr[n_ack] <= adr;
         ack_dat[n_ack] <= dat_o;
         ack_we[n_ack]  <= we;
         ack_sel[n_ack] <= sel;
         n_ack          <= n_ack + 1;
      end
      if (stb) stb_run <= stb_run + 1;
      else if (stb_run > 0) begin
         if (n_pulse < 64) stb_len[n_pulse] <= stb_run;
         n_pulse <= n_pulse + 1;
         stb_run <= 0;
      end
      cyc_prev <= cyc;
      if (cyc_prev && !cyc) cyc_falls <= cyc_falls + 1;
   end

   // response log filled by do_cmd
   logic [31:0] r_data[32];
   logic        r_last[32], r_err[32];
   int          r_n, lat, span, stall_viol;
   logic        rdy_after, stb_at_hs;

   task automatic clear_logs();
      n_ack = 0; n_pulse = 0; cyc_falls = 0; r_n = 0; stall_viol = 0; lat = -1; span = -1;
   endtask

   // issue one command at a negedge, collect every response beat; stall RSP_READY st_n cycles on beat st_beat
   task automatic do_cmd(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic [3:0] l, input int st_beat, input int st_n);
      int g, t;
      logic [31:0] snap;
      logic done;
      clear_logs();
      cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_sel = s; cmd_data = d; cmd_len = l;
      g = 0;
      while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
      if (!cmd_ready) begin
         n_cmp++; n_bad++; cmd_valid = 1'b0;
         $display("FAIL cmd_handshake: CMD_READY stayed 0 for 50 cycles, expected 1");
         return;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      stb_at_hs = stb;
      t = 0; g = 0; done = 1'b0;
      while (!done && g < 2000) begin
         if (rsp_valid) begin
            if (lat < 0) lat = t;
            if (r_n == st_beat) begin
               snap = rsp_data;
               for (int k = 0; k < st_n; k++) begin
                  if (!rsp_valid || rsp_data !== snap || stb !== 1'b0 || cyc !== !rsp_last) stall_viol++;
                  @(negedge clk); t++;
               end
            end
            r_data[r_n] = rsp_data; r_last[r_n] = rsp_last; r_err[r_n] = rsp_err;
            r_n++; span = t;
            done = rsp_last || r_n >= 32;
            rsp_ready = 1'b1;
            @(negedge clk); t++;
            rsp_ready = 1'b0;
         end else begin
            @(negedge clk); t++; g++;
         end
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL rsp_wait: only %0d beats before budget expired, last beat never seen", r_n);
      end
      rdy_after = cmd_ready;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if ({cyc, stb, we, sel, adr, dat_o, rsp_valid, rsp_data, rsp_err, rsp_last} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got cyc=%b stb=%b rsp_valid=%b adr=%h, expected all 0", cyc, stb, rsp_valid, adr);
      end
      n_cmp++;
      if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL release_cmd_ready: got %b expected 1", cmd_ready); end
   endtask

   task automatic test_write();
      waits = 2; key = '0; ack_en = 1'b1;
      do_cmd(1'b1, 32'h3000_0004, 4'hF, 32'hDEAD_BEEF, 4'd7, -1, 0);
      n_cmp++; if (stb_at_hs !== 1'b1) begin n_bad++; $display("FAIL wr_stb_latency: STB_O=%b one cycle after handshake, expected 1", stb_at_hs); end
      n_cmp++; if (n_ack !== 1) begin n_bad++; $display("FAIL wr_acks: got %0d expected 1", n_ack); end
      n_cmp++; if (ack_adr[0] !== 32'h3000_0004 || ack_we[0] !== 1'b1 || ack_sel[0] !== 4'hF || ack_dat[0] !== 32'hDEAD_BEEF) begin
         n_bad++; $display("FAIL wr_bus: got adr=%h we=%b sel=%h dat=%h expected 30000004 1 f deadbeef", ack_adr[0], ack_we[0], ack_sel[0], ack_dat[0]);
      end
      n_cmp++; if (n_pulse !== 1 || stb_len[0] !== 3) begin n_bad++; $display("FAIL wr_stb_pulse: got %0d pulses len %0d expected 1 pulse len 3", n_pulse, stb_len[0]); end
      n_cmp++; if (r_n !== 1 || r_data[0] !== 32'h0 || r_last[0] !== 1'b1 || r_err[0] !== 1'b0) begin
         n_bad++; $display("FAIL wr_rsp: got beats=%0d data=%h last=%b err=%b expected 1 0 1 0", r_n, r_data[0], r_last[0], r_err[0]);
      end
      n_cmp++; if (rdy_after !== 1'b1) begin n_bad++; $display("FAIL wr_ready_after: got %b expected 1", rdy_after); end
   endtask

   task automatic test_read();
      logic [31:0] ea;
      waits = 0; key = '0; ack_en = 1'b1;
      do_cmd(1'b0, 32'h3000_0000, 4'hF, 32'h0, 4'd3, -1, 0);
      n_cmp++; if (r_n !== 4 || n_ack !== 4) begin n_bad++; $display("FAIL rd_beats: got %0d beats %0d acks expected 4 4", r_n, n_ack); end
      for (int i = 0; i < 4; i++) begin
         ea = 32'h3000_0000 + 32'(4 * i);
         n_cmp++;
         if (ack_adr[i] !== ea || ack_we[i] !== 1'b0 || r_data[i] !== ea || r_last[i] !== (i == 3) || r_err[i] !== 1'b0) begin
            n_bad++; $display("FAIL rd_beat%0d: got adr=%h data=%h last=%b expected adr=%h data=%h last=%b", i, ack_adr[i], r_data[i], r_last[i], ea, ea, i == 3);
         end
      end
      n_cmp++; if (cyc_falls !== 1) begin n_bad++; $display("FAIL rd_cyc_held: CYC_O fell %0d times, expected 1", cyc_falls); end
      n_cmp++; if (lat !== 1 || span !== 7) begin n_bad++; $display("FAIL rd_timing: first beat after %0d, last at %0d, expected 1 and 7", lat, span); end
      n_cmp++; if (rdy_after !== 1'b1) begin n_bad++; $display("FAIL rd_ready_after: got %b expected 1", rdy_after); end
   endtask

   task automatic test_stall();
      logic [31:0] a, ea;
      waits = 1; key = $urandom; ack_en = 1'b1;
      a = $urandom & 32'hFFFF_FFC0;
      do_cmd(1'b0, a, 4'h5, 32'h0, 4'd3, 1, 5);
      n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("FAIL stall_stable: %0d unstable cycles, expected 0", stall_viol); end
      n_cmp++; if (r_n !== 4) begin n_bad++; $display("FAIL stall_beats: got %0d expected 4", r_n); end
      for (int i = 0; i < 4; i++) begin
         ea = a + 32'(4 * i);
         n_cmp++;
         if (r_data[i] !== (ea ^ key) || ack_sel[i] !== 4'h5) begin
            n_bad++; $display("FAIL stall_beat%0d: got data=%h sel=%h expected %h 5", i, r_data[i], ack_sel[i], ea ^ key);
         end
      end
   endtask

   task automatic test_wrap();
      waits = 0; key = 32'h5A5A_0000; ack_en = 1'b1;
      do_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0, 4'd1, -1, 0);
      n_cmp++; if (n_ack !== 2 || ack_adr[0] !== 32'hFFFF_FFFC || ack_adr[1] !== 32'h0) begin
         n_bad++; $display("FAIL wrap_adr: got %0d acks adr1=%h expected 2 00000000", n_ack, ack_adr[1]);
      end
      n_cmp++; if (r_data[1] !== 32'h5A5A_0000 || r_last[1] !== 1'b1) begin
         n_bad++; $display("FAIL wrap_rsp: got data=%h last=%b expected 5a5a0000 1", r_data[1], r_last[1]);
      end
   endtask

`ifdef WB_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      ack_en = 1'b0; waits = 0;
      do_cmd(1'b0, 32'h3000_0100, 4'hF, 32'h0, 4'd3, -1, 0);
      n_cmp++; if (r_n !== 1 || r_err[0] !== 1'b1 || r_last[0] !== 1'b1 || r_data[0] !== 32'h0) begin
         n_bad++; $display("FAIL tmo_rsp: got beats=%0d err=%b last=%b data=%h expected 1 1 1 0", r_n, r_err[0], r_last[0], r_data[0]);
      end
      n_cmp++; if (n_pulse !== 1 || stb_len[0] !== TMO || n_ack !== 0) begin
         n_bad++; $display("FAIL tmo_stb: got %0d pulses len %0d acks %0d expected 1 %0d 0", n_pulse, stb_len[0], n_ack, TMO);
      end
      n_cmp++; if (rdy_after !== 1'b1 || cyc !== 1'b0) begin n_bad++; $display("FAIL tmo_ready: got ready=%b cyc=%b expected 1 0", rdy_after, cyc); end
      ack_en = 1'b1;
   endtask
`endif

   task automatic test_reset_mid();
      int hold;
      logic [3:0] l;
      logic [31:0] a;
`ifdef WB_MASTER_TIMEOUT_EN
      hold = 3;
`else
      hold = 300;
`endif
      ack_en = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_0200; cmd_sel = 4'hF; cmd_len = 4'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (hold) @(negedge clk);
      n_cmp++; if (cyc !== 1'b1 || stb !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL noack_wait: got cyc=%b stb=%b rsp_valid=%b err=%b after %0d cycles, expected 1 1 0 0", cyc, stb, rsp_valid, rsp_err, hold);
      end
      rst = 1'b1;
      #1;
      n_cmp++; if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         n_bad++; $display("FAIL rst_mid: got cyc=%b stb=%b rsp_valid=%b ready=%b expected 0 0 0 0", cyc, stb, rsp_valid, cmd_ready);
      end
      @(negedge clk);
      rst = 1'b0; ack_en = 1'b1; waits = 1; key = 32'h0F0F_0F0F;
      l = 4'($urandom_range(0, 15));
      a = $urandom & 32'hFFFF_FFFC;
      do_cmd(1'b0, a, 4'hF, 32'h0, l, -1, 0);
      n_cmp++; if (r_n !== int'(l) + 1) begin n_bad++; $display("FAIL post_rst_beats: got %0d expected %0d", r_n, int'(l) + 1); end
      n_cmp++; if (r_data[0] !== (a ^ key) || r_last[r_n - 1] !== 1'b1) begin
         n_bad++; $display("FAIL post_rst_rsp: got data=%h expected %h", r_data[0], a ^ key);
      end
   endtask

   task automatic test_random();
      logic w;
      logic [31:0] a, d, ea;
      logic [3:0] s, l;
      int nb, sb, sn;
      for (int it = 0; it < 25; it++) begin
         w = 1'($urandom_range(0, 1));
         a = (it % 5 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         s = 4'($urandom); d = $urandom; l = 4'($urandom);
         waits = $urandom_range(0, 3); key = $urandom; ack_en = 1'b1;
         nb = w ? 1 : int'(l) + 1;
         sb = $urandom_range(0, nb - 1); sn = $urandom_range(0, 3);
         do_cmd(w, a, s, d, l, sb, sn);
         n_cmp++; if (r_n !== nb || n_ack !== nb) begin n_bad++; $display("FAIL rnd%0d_beats: got %0d beats %0d acks expected %0d", it, r_n, n_ack, nb); end
         for (int i = 0; i < nb && i < r_n; i++) begin
            ea = a + 32'(4 * i);
            n_cmp++;
            if (r_data[i] !== (w ? 32'h0 : ea ^ key) || r_last[i] !== (i == nb - 1) || r_err[i] !== 1'b0 ||
                ack_adr[i] !== ea || ack_we[i] !== w || ack_sel[i] !== s || (w && ack_dat[i] !== d)) begin
               n_bad++; $display("FAIL rnd%0d_beat%0d: got data=%h last=%b adr=%h we=%b sel=%h expected data=%h last=%b adr=%h we=%b sel=%h",
                                 it, i, r_data[i], r_last[i], ack_adr[i], ack_we[i], ack_sel[i], w ? 32'h0 : ea ^ key, i == nb - 1, ea, w, s);
            end
         end
         n_cmp++; if (stall_viol !== 0 || rdy_after !== 1'b1) begin
            n_bad++; $display("FAIL rnd%0d_hs: got stall_viol=%0d ready=%b expected 0 1", it, stall_viol, rdy_after);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_stall();
      test_wrap();
`ifdef WB_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
